// File: rtl/rp_scope_dec_pkg.sv
// Shared scope-channel constants and helpers.
//   DEC_LOG2_MAX   largest supported decimation exponent k
//   ACC_W          default accumulator width (sample width + DEC_LOG2_MAX)
//   acc_width()    accumulator width for a given sample width / k range
//   dec_log2_sat() clamps a requested k to the supported maximum
package rp_scope_pkg;

  localparam int unsigned DEC_LOG2_MAX = 16;
  localparam int unsigned DBITS_DFLT   = 16;
  localparam int unsigned ACC_W        = DBITS_DFLT + DEC_LOG2_MAX;

  function automatic int unsigned acc_width(input int unsigned dbits,
                                            input int unsigned dec_log2_max);
    return dbits + dec_log2_max;
  endfunction

  function automatic logic [4:0] dec_log2_sat(input logic [4:0]      k,
                                              input int unsigned     k_max);
    logic [4:0] k_max_5;
    k_max_5 = 5'(k_max);
    return (32'(k) > k_max) ? k_max_5 : k;
  endfunction

endpackage

// File: rtl/rp_scope_dec_acc.sv
// Block counter, accumulator and completion detect for the decimator.
//   clk, rst_n  sample clock, async active-low reset
//   dat         calibrated sample (signed), dat_valid qualifies it
//   clr         synchronous clear: drops the partial block and the sample
//   k           decimation exponent for the current block (already clamped)
//   sum         running sum including the current sample (combinational)
//   last        current sample, passed through
//   done        current sample completes the block (combinational)
module rp_scope_dec_acc #(
  parameter int unsigned DBITS        = 16,
  parameter int unsigned DEC_LOG2_MAX = 16,
  parameter int unsigned AW           = DBITS + DEC_LOG2_MAX
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [DBITS-1:0] dat,
  input  logic                    dat_valid,
  input  logic                    clr,
  input  logic [4:0]              k,
  output logic signed [AW-1:0]    sum,
  output logic signed [DBITS-1:0] last,
  output logic                    done
);

  logic [DEC_LOG2_MAX-1:0] cnt;
  logic [DEC_LOG2_MAX-1:0] mask;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    dat_ext;
  logic                    accept;

  assign accept  = dat_valid & ~clr;
  // 2^k - 1; a shift by the full counter width yields all ones
  assign mask    = ~({DEC_LOG2_MAX{1'b1}} << k);
  assign dat_ext = {{(AW-DBITS){dat[DBITS-1]}}, dat};
  // first sample of a block restarts the sum instead of adding to it
  assign sum     = (cnt == '0) ? dat_ext : acc + dat_ext;
  assign last    = dat;
  assign done    = accept && (cnt == mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (clr) begin
      cnt <= '0;
      acc <= '0;
    end else if (dat_valid) begin
      cnt <= done ? '0 : cnt + 1'b1;
      acc <= sum;
    end
  end

endmodule

// File: rtl/rp_scope_dec.sv
// Decimation / averaging stage for one scope channel.
//   adc_clk_i, adc_rstn_i   sample clock, async active-low reset
//   s_dat_i, s_dat_tvalid_i calibrated input stream
//   m_dat_o, m_dat_tvalid_o decimated stream, one-cycle valid pulse
//   cfg_dec_log2_i          k (N = 2^k), clamped to DEC_LOG2_MAX
//   cfg_avg_en_i            1: block average, 0: last sample of block
//   cfg_clr_i               synchronous clear
// Config is latched into shadow registers on the first clock after reset,
// at every block completion and on clear; a block always runs on shadows.
module rp_scope_dec #(
  parameter int unsigned DBITS        = 16,
  parameter int unsigned DEC_LOG2_MAX = rp_scope_pkg::DEC_LOG2_MAX
) (
  input  logic                    adc_clk_i,
  input  logic                    adc_rstn_i,
  input  logic signed [DBITS-1:0] s_dat_i,
  input  logic                    s_dat_tvalid_i,
  output logic signed [DBITS-1:0] m_dat_o,
  output logic                    m_dat_tvalid_o,
  input  logic [4:0]              cfg_dec_log2_i,
  input  logic                    cfg_avg_en_i,
  input  logic                    cfg_clr_i
);

  localparam int unsigned AW = rp_scope_pkg::acc_width(DBITS, DEC_LOG2_MAX);

  logic [4:0]              k_cfg;
  logic [4:0]              k_s;
  logic [4:0]              k_use;
  logic                    avg_s;
  logic                    avg_use;
  logic                    primed;

  logic signed [AW-1:0]    sum;
  logic signed [DBITS-1:0] last;
  logic                    done;

  logic                    s1_valid;
  logic signed [AW-1:0]    s1_val;
  logic [4:0]              s1_k;
  logic signed [AW-1:0]    s1_shift;

  assign k_cfg = rp_scope_pkg::dec_log2_sat(cfg_dec_log2_i, DEC_LOG2_MAX);

  // Shadows are not yet loaded on the very first clock, so that clock
  // runs on the live config it is about to capture.
  assign k_use   = primed ? k_s   : k_cfg;
  assign avg_use = primed ? avg_s : cfg_avg_en_i;

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      primed <= 1'b0;
      k_s    <= '0;
      avg_s  <= 1'b0;
    end else begin
      primed <= 1'b1;
      if (!primed || done || cfg_clr_i) begin
        k_s   <= k_cfg;
        avg_s <= cfg_avg_en_i;
      end
    end
  end

  rp_scope_dec_acc #(
    .DBITS        (DBITS),
    .DEC_LOG2_MAX (DEC_LOG2_MAX),
    .AW           (AW)
  ) u_acc (
    .clk       (adc_clk_i),
    .rst_n     (adc_rstn_i),
    .dat       (s_dat_i),
    .dat_valid (s_dat_tvalid_i),
    .clr       (cfg_clr_i),
    .k         (k_use),
    .sum       (sum),
    .last      (last),
    .done      (done)
  );

  // Stage 1 keeps the shift amount of the finished block, since the
  // shadow k may already have moved on to the next block's value.
  // Last-sample mode is carried as a zero shift of the sign-extended sample.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_k     <= '0;
    end else begin
      s1_valid <= done;
      if (done) begin
        s1_val <= avg_use ? sum : {{(AW-DBITS){last[DBITS-1]}}, last};
        s1_k   <= avg_use ? k_use : '0;
      end
    end
  end

  assign s1_shift = s1_val >>> s1_k;

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      m_dat_o        <= '0;
      m_dat_tvalid_o <= 1'b0;
    end else begin
      m_dat_tvalid_o <= s1_valid & ~cfg_clr_i;
      if (s1_valid && !cfg_clr_i) begin
        m_dat_o <= s1_shift[DBITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_rp_scope_dec.sv
// Directed bench for rp_scope_dec with an expected-output queue.
module tb_rp_scope_dec;

  logic               adc_clk_i = 1'b0;
  logic               adc_rstn_i = 1'b0;
  logic signed [15:0] s_dat_i = '0;
  logic               s_dat_tvalid_i = 1'b0;
  logic signed [15:0] m_dat_o;
  logic               m_dat_tvalid_o;
  logic [4:0]         cfg_dec_log2_i = '0;
  logic               cfg_avg_en_i = 1'b1;
  logic               cfg_clr_i = 1'b0;

  rp_scope_dec #(
    .DBITS        (16),
    .DEC_LOG2_MAX (16)
  ) dut (
    .adc_clk_i      (adc_clk_i),
    .adc_rstn_i     (adc_rstn_i),
    .s_dat_i        (s_dat_i),
    .s_dat_tvalid_i (s_dat_tvalid_i),
    .m_dat_o        (m_dat_o),
    .m_dat_tvalid_o (m_dat_tvalid_o),
    .cfg_dec_log2_i (cfg_dec_log2_i),
    .cfg_avg_en_i   (cfg_avg_en_i),
    .cfg_clr_i      (cfg_clr_i)
  );

  initial forever #5 adc_clk_i = ~adc_clk_i;

  int cyc = 0;
  always @(posedge adc_clk_i) cyc <= cyc + 1;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   last_cyc = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and are accepted on
  // the next one; outputs are sampled on the falling edge.
  task automatic drive(input int d, input bit v, input bit c);
    @(posedge adc_clk_i);
    #1;
    s_dat_i        = 16'(d);
    s_dat_tvalid_i = v;
    cfg_clr_i      = c;
  endtask

  task automatic send(input int d);
    drive(d, 1'b1, 1'b0);
    last_cyc = cyc;
  endtask

  task automatic gap(input int d);
    drive(d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1'b0, 1'b0);
  endtask

  task automatic clear();
    drive(0, 1'b0, 1'b1);
  endtask

  task automatic set_cfg(input int k, input bit avg);
    cfg_dec_log2_i = 5'(k);
    cfg_avg_en_i   = avg;
  endtask

  task automatic expect_out(input int v);
    exp_t e;
    e.val = v;
    e.cyc = last_cyc + 2;
    sb.push_back(e);
  endtask

  always @(negedge adc_clk_i) begin
    if (adc_rstn_i && m_dat_tvalid_o) begin
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: observed data %0d at cycle %0d expected no pulse",
               m_dat_o, cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", m_dat_o, e.val);
        chk("out_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    // reset state
    set_cfg(0, 1'b1);
    repeat (3) @(posedge adc_clk_i);
    #1;
    chk("rst_data", m_dat_o, 0);
    chk("rst_valid", m_dat_tvalid_o, 0);
    adc_rstn_i = 1'b1;

    // k=0 pass-through, back-to-back
    send(100);   expect_out(100);
    send(-5);    expect_out(-5);
    send(32767); expect_out(32767);
    idle(4);

    // k=2 average, floor on negative sums, then last-sample mode
    set_cfg(2, 1'b1);
    clear();
    send(1); send(2); send(3); send(4); expect_out(2);
    send(-1); send(-2); send(-3); send(-4); expect_out(-3);
    idle(3);
    set_cfg(2, 1'b0);
    clear();
    send(1); send(2); send(3); send(4); expect_out(4);
    idle(3);

    // gaps in tvalid: data on idle cycles must be ignored
    set_cfg(2, 1'b1);
    clear();
    send(1); gap(77); gap(77); send(2); send(3); gap(77); send(4);
    expect_out(2);
    idle(3);

    // mid-block k change applies at the block boundary
    send(10); send(20);
    set_cfg(1, 1'b1);
    send(30); send(40); expect_out(25);
    send(7); send(8); expect_out(7);
    send(5); send(6); expect_out(5);
    idle(3);

    // clear discards a partial block
    set_cfg(2, 1'b1);
    clear();
    send(9); send(9); send(9);
    clear();
    send(4); send(4); send(4); send(4); expect_out(4);
    idle(3);

    // clear on the completing sample: no output
    send(1); send(1); send(1);
    drive(1, 1'b1, 1'b1);
    idle(3);

    // clear right after completion kills the output in flight
    send(8); send(8); send(8); send(8);
    clear();
    idle(3);

    // async reset mid-pipeline forces outputs low immediately
    set_cfg(0, 1'b1);
    clear();
    send(123); expect_out(123);
    send(124); expect_out(124);
    idle(1);
    @(negedge adc_clk_i);
    #1;
    adc_rstn_i = 1'b0;
    #1;
    chk("async_rst_data", m_dat_o, 0);
    chk("async_rst_valid", m_dat_tvalid_o, 0);
    sb.delete();
    @(posedge adc_clk_i);
    #1;
    adc_rstn_i = 1'b1;
    send(55); expect_out(55);
    idle(4);

    // k=31 clamps to 16; one full block at the negative extreme
    set_cfg(31, 1'b1);
    clear();
    for (int i = 0; i < 65536; i++) send(-32768);
    expect_out(-32768);
    idle(4);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
